// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and helpers for the multi-pattern serial sequence detector.
//   state_t      : detector FSM states (DISABLED / FILL / ACTIVE)
//   MAX_PAT_LEN  : widest pattern the detector supports
//   pattern_hit  : masked compare of a candidate window against one pattern
package seq_det_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FILL     = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam int MAX_PAT_LEN = 16;

    // An all-zero mask marks the entry as unused, so it must never report a hit
    // even though the masked difference is trivially zero.
    function automatic logic pattern_hit(
        input logic [MAX_PAT_LEN-1:0] cand,
        input logic [MAX_PAT_LEN-1:0] pat,
        input logic [MAX_PAT_LEN-1:0] mask
    );
        return (mask != '0) && (((cand ^ pat) & mask) == '0);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// seq_det_match
//   One pattern entry of the sequence detector: pattern/mask registers, masked
//   compare, registered match pulse and saturating match counter.
// Ports
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   cfg_we       : write cfg_pattern/cfg_mask into this entry
//   cfg_pattern  : pattern, bit PAT_LEN-1 oldest, bit 0 newest
//   cfg_mask     : 1 = compare bit, 0 = don't care
//   cand         : current candidate window from the shared history
//   eval         : the candidate is a real evaluation this cycle
//   clr_cnt      : synchronous counter clear (wins over a hit)
//   hit          : combinational compare result (used by the FSM for non-overlap)
//   match        : registered one-cycle match pulse
//   cnt          : saturating match counter
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [PAT_LEN-1:0] cfg_mask,
    input  logic [PAT_LEN-1:0] cand,
    input  logic               eval,
    input  logic               clr_cnt,
    output logic               hit,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] mask_q;

    assign hit = pattern_hit(MAX_PAT_LEN'(cand), MAX_PAT_LEN'(pat_q), MAX_PAT_LEN'(mask_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q  <= '0;
            mask_q <= '0;
        end else if (cfg_we) begin
            pat_q  <= cfg_pattern;
            mask_q <= cfg_mask;
        end
    end

    // Counter holds at all-ones instead of wrapping; clear has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match <= 1'b0;
            cnt   <= '0;
        end else begin
            match <= eval && hit;
            if (clr_cnt) begin
                cnt <= '0;
            end else if (eval && hit && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_multi.sv
// seq_detector_multi
//   Serial sequence detector with N_PAT runtime-programmable, maskable patterns
//   of PAT_LEN bits each, overlapping or non-overlapping detection.
// Ports
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   en           : detector enable; low flushes history and disables detection
//   overlap      : 1 = overlapping detection, 0 = restart after every hit
//   in_valid     : in_bit carries a stream bit this cycle
//   in_bit       : serial data bit
//   cfg_load     : write entry cfg_idx (accepted only while DISABLED)
//   cfg_idx      : entry index; out-of-range indexes are rejected
//   cfg_pattern  : pattern, bit PAT_LEN-1 oldest, bit 0 newest
//   cfg_mask     : compare mask, all-zero disables the entry
//   clr_cnt      : synchronous clear of all match counters
//   match        : per-pattern one-cycle registered match pulse
//   match_cnt    : packed saturating counters, entry i at [i*CNT_W +: CNT_W]
//   cfg_err      : one-cycle pulse when a cfg_load is rejected
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 3,
    parameter int N_PAT   = 2,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   overlap,
    input  logic                   in_valid,
    input  logic                   in_bit,
    input  logic                   cfg_load,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [PAT_LEN-1:0]     cfg_pattern,
    input  logic [PAT_LEN-1:0]     cfg_mask,
    input  logic                   clr_cnt,
    output logic [N_PAT-1:0]       match,
    output logic [N_PAT*CNT_W-1:0] match_cnt,
    output logic                   cfg_err
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);

    state_t              state_q, state_d;
    logic [PAT_LEN-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [PAT_LEN-1:0]  cand;
    logic [N_PAT-1:0]    hit;
    logic                eval;
    logic                cfg_ok;

    // The newest bit is appended below the retained history to form the window.
    assign cand = {hist_q, in_bit};

    assign cfg_ok = cfg_load && (state_q == DISABLED) && (32'(cfg_idx) < N_PAT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DISABLED;
            hist_q  <= '0;
            fill_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cfg_err <= cfg_load && !cfg_ok;
        end
    end

    // The sample that completes the fill is already evaluated, so the very
    // first PAT_LEN bits after enabling can produce a match.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        eval    = 1'b0;
        if (!en) begin
            state_d = DISABLED;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                DISABLED: begin
                    state_d = FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
                FILL: begin
                    if (in_valid) begin
                        hist_d = cand[PAT_LEN-2:0];
                        fill_d = fill_q + FILL_W'(1);
                        if (fill_q == FILL_W'(PAT_LEN - 1)) begin
                            eval    = 1'b1;
                            state_d = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (in_valid) begin
                        hist_d = cand[PAT_LEN-2:0];
                        eval   = 1'b1;
                    end
                end
                default: begin
                    state_d = DISABLED;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
            // Non-overlapping mode: any hit throws away the window so the next
            // match must be built from PAT_LEN fresh bits.
            if (eval && (|hit) && !overlap) begin
                state_d = FILL;
                hist_d  = '0;
                fill_d  = '0;
            end
        end
    end

    for (genvar i = 0; i < N_PAT; i++) begin : g_entry
        seq_det_match #(
            .PAT_LEN (PAT_LEN),
            .CNT_W   (CNT_W)
        ) u_match (
            .clk         (clk),
            .rstn        (rstn),
            .cfg_we      (cfg_ok && (cfg_idx == IDX_W'(i))),
            .cfg_pattern (cfg_pattern),
            .cfg_mask    (cfg_mask),
            .cand        (cand),
            .eval        (eval),
            .clr_cnt     (clr_cnt),
            .hit         (hit[i]),
            .match       (match[i]),
            .cnt         (match_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_seq_detector_multi.sv
// tb_seq_detector_multi
//   Directed bench for seq_detector_multi. Instance a uses PAT_LEN=3, N_PAT=2,
//   CNT_W=4; instance b shares all stimulus except cfg_idx and uses N_PAT=3,
//   CNT_W=2 so that counter saturation and out-of-range indexes are reachable.
module tb_seq_detector_multi;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       overlap;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_load;
    logic       cfg_idx_a;
    logic [1:0] cfg_idx_b;
    logic [2:0] cfg_pattern;
    logic [2:0] cfg_mask;
    logic       clr_cnt;

    logic [1:0] match_a;
    logic [7:0] match_cnt_a;
    logic       cfg_err_a;
    logic [2:0] match_b;
    logic [5:0] match_cnt_b;
    logic       cfg_err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_detector_multi #(.PAT_LEN(3), .N_PAT(2), .CNT_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .overlap(overlap),
        .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
        .cfg_idx(cfg_idx_a), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .clr_cnt(clr_cnt), .match(match_a), .match_cnt(match_cnt_a),
        .cfg_err(cfg_err_a)
    );

    seq_detector_multi #(.PAT_LEN(3), .N_PAT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .overlap(overlap),
        .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
        .cfg_idx(cfg_idx_b), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .clr_cnt(clr_cnt), .match(match_b), .match_cnt(match_cnt_b),
        .cfg_err(cfg_err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic setEnable(input logic v, input logic clr);
        en      = v;
        clr_cnt = clr;
        step();
        clr_cnt = 1'b0;
    endtask

    task automatic loadCfg(input logic ia, input logic [1:0] ib, input logic [2:0] p, input logic [2:0] m);
        cfg_idx_a   = ia;
        cfg_idx_b   = ib;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_load    = 1'b1;
        step();
        cfg_load    = 1'b0;
    endtask

    // bits/expectations are written first-bit-leftmost: index n-1 is sent first.
    task automatic runStream(input string tag, input int n, input logic [15:0] bits,
                             input logic [15:0] e0, input logic [15:0] e1a, input logic [15:0] e1b);
        for (int k = n - 1; k >= 0; k--) begin
            applyStimulus(1'b1, bits[k]);
            checkOutput($sformatf("%s_a_bit%0d", tag, n - k), 32'(match_a), 32'({e1a[k], e0[k]}));
            checkOutput($sformatf("%s_b_bit%0d", tag, n - k), 32'(match_b), 32'({1'b0, e1b[k], e0[k]}));
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; overlap = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        cfg_load = 1'b0; cfg_idx_a = 1'b0; cfg_idx_b = 2'd0;
        cfg_pattern = 3'b000; cfg_mask = 3'b000; clr_cnt = 1'b0;
        #3;
        checkOutput("reset_match_a", 32'(match_a), 32'h0);
        checkOutput("reset_cnt_a", 32'(match_cnt_a), 32'h0);
        checkOutput("reset_err_a", 32'(cfg_err_a), 32'h0);
        checkOutput("reset_cnt_b", 32'(match_cnt_b), 32'h0);
        #10 rstn = 1'b1;
        step();

        $display("[TB] test 1: overlapping detection");
        loadCfg(1'b0, 2'd0, 3'b111, 3'b111);
        checkOutput("cfg0_err", 32'(cfg_err_a), 32'h0);
        loadCfg(1'b1, 2'd1, 3'b010, 3'b111);
        overlap = 1'b1;
        setEnable(1'b1, 1'b0);
        runStream("t1", 7, 16'b1111010, 16'b0011000, 16'b0000001, 16'b0000001);
        checkOutput("t1_cnt0", 32'(match_cnt_a[3:0]), 32'd2);
        checkOutput("t1_cnt1", 32'(match_cnt_a[7:4]), 32'd1);

        $display("[TB] test 2: non-overlapping detection");
        setEnable(1'b0, 1'b1);
        overlap = 1'b0;
        setEnable(1'b1, 1'b0);
        runStream("t2", 6, 16'b111111, 16'b001001, 16'b0, 16'b0);
        checkOutput("t2_cnt0", 32'(match_cnt_a[3:0]), 32'd2);

        $display("[TB] test 3: don't-care mask bit");
        setEnable(1'b0, 1'b1);
        loadCfg(1'b0, 2'd0, 3'b101, 3'b101);
        overlap = 1'b1;
        setEnable(1'b1, 1'b0);
        runStream("t3", 6, 16'b101111, 16'b001011, 16'b0, 16'b0);
        checkOutput("t3_cnt0", 32'(match_cnt_a[3:0]), 32'd3);

        $display("[TB] test 4: counter saturation and clear priority");
        setEnable(1'b0, 1'b1);
        loadCfg(1'b0, 2'd0, 3'b111, 3'b111);
        setEnable(1'b1, 1'b0);
        runStream("t4", 8, 16'b11111111, 16'b00111111, 16'b0, 16'b0);
        checkOutput("t4_cnt0_a", 32'(match_cnt_a[3:0]), 32'd6);
        checkOutput("t4_cnt0_b_sat", 32'(match_cnt_b[1:0]), 32'd3);
        clr_cnt = 1'b1;
        applyStimulus(1'b1, 1'b1);
        clr_cnt = 1'b0;
        checkOutput("t4_clr_match", 32'(match_a), 32'h1);
        checkOutput("t4_clr_cnt_a", 32'(match_cnt_a[3:0]), 32'd0);
        checkOutput("t4_clr_cnt_b", 32'(match_cnt_b[1:0]), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t4_after_clr_cnt", 32'(match_cnt_a[3:0]), 32'd1);

        $display("[TB] test 5: configuration rules");
        loadCfg(1'b0, 2'd0, 3'b000, 3'b111);
        checkOutput("t5_err_enabled_a", 32'(cfg_err_a), 32'h1);
        checkOutput("t5_err_enabled_b", 32'(cfg_err_b), 32'h1);
        step();
        checkOutput("t5_err_pulse_end", 32'(cfg_err_a), 32'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5_entry_kept", 32'(match_a), 32'h1);
        setEnable(1'b0, 1'b0);
        loadCfg(1'b1, 2'd3, 3'b010, 3'b000);
        checkOutput("t5_zero_mask_err_a", 32'(cfg_err_a), 32'h0);
        checkOutput("t5_bad_idx_err_b", 32'(cfg_err_b), 32'h1);
        setEnable(1'b1, 1'b0);
        runStream("t5", 3, 16'b010, 16'b000, 16'b000, 16'b001);

        $display("[TB] test 6: enable drop and async reset");
        setEnable(1'b0, 1'b0);
        setEnable(1'b1, 1'b0);
        runStream("t6a", 2, 16'b11, 16'b00, 16'b0, 16'b0);
        setEnable(1'b0, 1'b0);
        setEnable(1'b1, 1'b0);
        runStream("t6b", 3, 16'b111, 16'b001, 16'b0, 16'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6_pre_reset_match", 32'(match_a), 32'h1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("t6_async_match_a", 32'(match_a), 32'h0);
        checkOutput("t6_async_cnt_a", 32'(match_cnt_a), 32'h0);
        checkOutput("t6_async_match_b", 32'(match_b), 32'h0);
        checkOutput("t6_async_cnt_b", 32'(match_cnt_b), 32'h0);
        #1 rstn = 1'b1;
        en = 1'b0;
        step();
        setEnable(1'b1, 1'b0);
        runStream("t6c", 3, 16'b111, 16'b000, 16'b0, 16'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
